// File: rtl/mips_div_pkg.sv
// Shared definitions for the MIPS HI/LO divide path.
// FSM encoding, default datapath width and the divide-by-zero quotient.
package mips_div_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;
endpackage

// File: rtl/divu_seq_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, trial-subtract the divisor.
// Purely combinational, no backpressure.
module div_step
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;

    // rem < divisor, so the shifted value and the trial both fit in WIDTH+1 bits.
    assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, i_divisor};

    always_comb begin
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_rem_sh[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/divu_seq.sv
// Sequential DIVU: quotient to mflo, remainder to mfhi, WIDTH+1 cycles (2 on divide-by-zero).
// Start accepted only when idle/done; busy stalls the pipeline. DIVU_SEQ_SIGNED_EN adds MIPS DIV.
module divu_seq
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_div_we,
`ifdef DIVU_SEQ_SIGNED_EN
    input  logic             i_div_signed,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_mfhi,
    output logic [WIDTH-1:0] o_mflo
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_mfhi;
    logic [WIDTH-1:0] r_mflo;

    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg_q;
    logic             w_neg_r;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_q_res;
    logic [WIDTH-1:0] w_r_res;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    assign w_b_zero = (i_b == '0);

    always_comb begin
        w_a_mag = i_a;
        w_b_mag = i_b;
        w_neg_q = 1'b0;
        w_neg_r = 1'b0;
`ifdef DIVU_SEQ_SIGNED_EN
        if (i_div_signed) begin
            if (i_a[WIDTH-1]) w_a_mag = -i_a;
            if (i_b[WIDTH-1]) w_b_mag = -i_b;
            w_neg_q = i_a[WIDTH-1] ^ i_b[WIDTH-1];
            w_neg_r = i_a[WIDTH-1];
        end
`endif
    end

    // Sign fix-up on the final iteration's outputs; flags are always 0 in unsigned use.
    assign w_q_res = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_res = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mfhi  <= '0;
            r_mflo  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (i_div_we) begin
                        // Divide-by-zero keeps the raw dividend so mfhi returns a unmodified.
                        r_quo   <= w_b_zero ? i_a : w_a_mag;
                        r_div   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= CNT_INIT;
                        r_neg_q <= w_neg_q;
                        r_neg_r <= w_neg_r;
                        r_busy  <= 1'b1;
                        r_state <= w_b_zero ? DZ : RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - CNT_LAST;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_mflo  <= w_q_res;
                        r_mfhi  <= w_r_res;
                    end
                end
                DZ: begin
                    r_rem   <= r_quo;
                    r_quo   <= {WIDTH{1'b1}};
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_mflo  <= {WIDTH{1'b1}};
                    r_mfhi  <= r_quo;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_mfhi = r_mfhi;
    assign o_mflo = r_mflo;
endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq: latency, results, divide-by-zero, ignored starts, back-to-back, reset abort.
module tb_divu_seq;
    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_we;
`ifdef DIVU_SEQ_SIGNED_EN
    logic        div_signed;
`endif
    logic        busy;
    logic        done;
    logic [31:0] mfhi;
    logic [31:0] mflo;

    int errors = 0;
    int checks = 0;

    divu_seq dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_a          (a),
        .i_b          (b),
        .i_div_we     (div_we),
`ifdef DIVU_SEQ_SIGNED_EN
        .i_div_signed (div_signed),
`endif
        .o_busy       (busy),
        .o_done       (done),
        .o_mfhi       (mfhi),
        .o_mflo       (mflo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: present a start request for the next rising edge.
    task automatic do_start(input logic [31:0] va, input logic [31:0] vb);
        a      = va;
        b      = vb;
        div_we = 1'b1;
    endtask

    // Counts cycles after the start edge until done; lat=-1 if done never arrives.
    task automatic wait_done(output int lat, output int busy_bad);
        lat      = -1;
        busy_bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) div_we = 1'b0;
            if (done) begin
                lat = k;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        div_we = 1'b0;
        a      = 32'hDEAD_BEEF;
        b      = 32'h1234_5678;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (mfhi !== 32'd0) begin errors++; $display("FAIL reset_mfhi got=%h exp=0", mfhi); end
        checks++; if (mflo !== 32'd0) begin errors++; $display("FAIL reset_mflo got=%h exp=0", mflo); end
    endtask

    task automatic test_basic();
        int lat, bb;
        do_start(32'd100, 32'd7);
        wait_done(lat, bb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33", lat); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy bad_cycles=%0d exp=0", bb); end
        checks++; if (mflo !== 32'd14) begin errors++; $display("FAIL basic_quo got=%0d exp=14", mflo); end
        checks++; if (mfhi !== 32'd2) begin errors++; $display("FAIL basic_rem got=%0d exp=2", mfhi); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (mflo !== 32'd14) begin errors++; $display("FAIL basic_hold got=%0d exp=14", mflo); end
    endtask

    task automatic test_edges();
        int lat, bb;
        do_start(32'hFFFF_FFFF, 32'd1);
        wait_done(lat, bb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL max_by_one_latency got=%0d exp=33", lat); end
        checks++; if (mflo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_by_one_quo got=%h exp=ffffffff", mflo); end
        checks++; if (mfhi !== 32'd0) begin errors++; $display("FAIL max_by_one_rem got=%h exp=0", mfhi); end
        @(negedge clk);
        do_start(32'd5, 32'hFFFF_FFFF);
        wait_done(lat, bb);
        checks++; if (mflo !== 32'd0) begin errors++; $display("FAIL small_by_max_quo got=%h exp=0", mflo); end
        checks++; if (mfhi !== 32'd5) begin errors++; $display("FAIL small_by_max_rem got=%h exp=5", mfhi); end
    endtask

    task automatic test_div_zero();
        int lat, bb;
        @(negedge clk);
        do_start(32'd1234, 32'd0);
        wait_done(lat, bb);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dz_latency got=%0d exp=2", lat); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL dz_busy bad_cycles=%0d exp=0", bb); end
        checks++; if (mflo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quo got=%h exp=ffffffff", mflo); end
        checks++; if (mfhi !== 32'd1234) begin errors++; $display("FAIL dz_rem got=%0d exp=1234", mfhi); end
    endtask

    task automatic test_ignore_and_back_to_back();
        int lat, bb;
        @(negedge clk);
        do_start(32'd50, 32'd5);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) div_we = 1'b0;
            if (k == 5) begin
                checks++; if (mflo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL run_hold_quo got=%h exp=ffffffff", mflo); end
                checks++; if (mfhi !== 32'd1234) begin errors++; $display("FAIL run_hold_rem got=%0d exp=1234", mfhi); end
            end
            if (k == 9) begin
                a      = 32'd999;
                b      = 32'd3;
                div_we = 1'b1;
            end
            if (k == 10) div_we = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
        checks++; if (mflo !== 32'd10) begin errors++; $display("FAIL ignore_quo got=%0d exp=10", mflo); end
        checks++; if (mfhi !== 32'd0) begin errors++; $display("FAIL ignore_rem got=%0d exp=0", mfhi); end
        do_start(32'd9, 32'd4);
        wait_done(lat, bb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL b2b_busy bad_cycles=%0d exp=0", bb); end
        checks++; if (mflo !== 32'd2) begin errors++; $display("FAIL b2b_quo got=%0d exp=2", mflo); end
        checks++; if (mfhi !== 32'd1) begin errors++; $display("FAIL b2b_rem got=%0d exp=1", mfhi); end
    endtask

    task automatic test_reset_mid();
        int lat, bb, pulses;
        @(negedge clk);
        do_start(32'd77, 32'd3);
        @(negedge clk);
        div_we = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (mflo !== 32'd0) begin errors++; $display("FAIL abort_mflo got=%h exp=0", mflo); end
        checks++; if (mfhi !== 32'd0) begin errors++; $display("FAIL abort_mfhi got=%h exp=0", mfhi); end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
        do_start(32'd77, 32'd3);
        wait_done(lat, bb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL restart_latency got=%0d exp=33", lat); end
        checks++; if (mflo !== 32'd25) begin errors++; $display("FAIL restart_quo got=%0d exp=25", mflo); end
        checks++; if (mfhi !== 32'd2) begin errors++; $display("FAIL restart_rem got=%0d exp=2", mfhi); end
    endtask

`ifdef DIVU_SEQ_SIGNED_EN
    task automatic test_signed();
        int lat, bb;
        @(negedge clk);
        div_signed = 1'b1;
        do_start(32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL signed_latency got=%0d exp=33", lat); end
        checks++; if (mflo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL signed_quo got=%h exp=fffffffd", mflo); end
        checks++; if (mfhi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed_rem got=%h exp=ffffffff", mfhi); end
        @(negedge clk);
        do_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bb);
        checks++; if (mflo !== 32'h8000_0000) begin errors++; $display("FAIL signed_ovf_quo got=%h exp=80000000", mflo); end
        checks++; if (mfhi !== 32'd0) begin errors++; $display("FAIL signed_ovf_rem got=%h exp=0", mfhi); end
        @(negedge clk);
        do_start(32'hFFFF_FFF9, 32'd0);
        wait_done(lat, bb);
        checks++; if (mflo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed_dz_quo got=%h exp=ffffffff", mflo); end
        checks++; if (mfhi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL signed_dz_rem got=%h exp=fffffff9", mfhi); end
        div_signed = 1'b0;
    endtask
`endif

    initial begin
`ifdef DIVU_SEQ_SIGNED_EN
        div_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignore_and_back_to_back();
        test_reset_mid();
`ifdef DIVU_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/divu_seq.md
Name: divu_seq

Overview:
- Multi-cycle unsigned integer divider for the MIPS datapath; the inverse of the HI/LO multiply path.
- Computes quotient into LO and remainder into HI for DIVU, using the same HI/LO output convention as the multiplier.
- Restoring radix-2 algorithm, one quotient bit per clock.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- div_we  input  1  start request; sampled only in IDLE or DONE.
- busy  output  1  high while division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- mfhi  output  WIDTH  remainder.
- mflo  output  WIDTH  quotient.

Behaviour:
- Reset (rst=1 at clk edge) forces state IDLE and busy=0, done=0, mfhi=0, mflo=0, with internal registers cleared. This has priority over everything else, including mid-operation (the division is aborted).
- States and transitions:
  - IDLE: on div_we=1, latch a into the quotient shift register, latch b into the divisor register, clear the partial remainder, load count=WIDTH, then go to RUN (or to DZ if b==0). Otherwise stay in IDLE.
  - RUN: busy=1 each cycle. Shift {rem,quo} left by 1, then form trial = rem_shifted − {1'b0,divisor} at WIDTH+1 bits.
    - If trial is non-negative: rem=trial[WIDTH-1:0] and quo[0]=1.
    - Otherwise rem=rem_shifted and quo[0]=0.
    - Decrement count. When count reaches 1 at the edge, go to DONE.
  - DZ: a single cycle with busy=1. Set quo=all ones and rem=a, then go to DONE.
  - DONE: done=1 for exactly this cycle and busy=0. mflo and mfhi are updated from quo/rem on entry to DONE and hold until the next accepted start or reset.
    - If div_we=1 here, a new operation starts immediately (back-to-back), with the same actions as from IDLE.
    - Otherwise go to IDLE.
- Latency:
  - Start edge to done=1 is WIDTH+1 cycles (33 at default): WIDTH RUN cycles plus DONE.
  - Divide-by-zero: 2 cycles.
- div_we while busy is ignored. Operands are not re-sampled, so a and b may change freely after the start edge.
- mfhi and mflo do NOT change during RUN; they show the previous result until DONE.
- Invariant: result satisfies a == mflo*b + mfhi with mfhi < b, for b != 0.
- No X propagation: all registers have defined reset values.

Optional Feature:
- Macro DIVU_SEQ_SIGNED_EN.
- Defined:
  - Adds input port div_signed (1 bit), sampled with div_we.
  - When div_signed=1, operands are converted to magnitudes at start and the sign flags are latched.
  - Before the DONE update, the quotient is negated if the signs differ, and the remainder takes the sign of the dividend (MIPS DIV semantics).
  - Overflow case a=0x80000000, b=0xFFFFFFFF yields mflo=0x80000000, mfhi=0.
  - Divide-by-zero gives mflo=all ones and mfhi=a regardless of sign.
  - Latency is unchanged.
- Undefined: no div_signed port; unsigned only.

Decomposition:
- Shared package mips_div_pkg:
  - state enum {IDLE, RUN, DZ, DONE} (2-bit encoding).
  - DIV_WIDTH=32 constant.
  - DIV_ZERO_QUO constant (all ones).
- One natural sub-module, div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in RUN datapath so it is independently unit-testable.

Test Plan:
- rst held 2 cycles, then released → busy=0, done=0, mfhi=0, mflo=0; div_we pulse with a=100, b=7 → done exactly 33 cycles later with mflo=14, mfhi=2; busy high on cycles 1–32.
- a=0xFFFFFFFF, b=1 → mflo=0xFFFFFFFF, mfhi=0; then a=5, b=0xFFFFFFFF → mflo=0, mfhi=5.
- a=1234, b=0 → done after 2 cycles, mflo=0xFFFFFFFF, mfhi=1234.
- Start a=50, b=5; toggle a/b and pulse div_we at cycle 10 → ignored, result mflo=10, mfhi=0. At the done cycle, assert div_we with a=9, b=4 → back-to-back completion 33 cycles later with mflo=2, mfhi=1.
- Assert rst at cycle 15 of a division → next cycle busy=0, mfhi=mflo=0, no done pulse; a new start then completes correctly.
- With DIVU_SEQ_SIGNED_EN defined, div_signed=1:
  - a=-7, b=2 → mflo=-3 (0xFFFFFFFD), mfhi=-1 (0xFFFFFFFF).
  - a=0x80000000, b=0xFFFFFFFF → mflo=0x80000000, mfhi=0.
